uart_rx: RTL
============

Name: uart_rx

Overview:
Fixed-format UART receiver: 8 data bits, no parity, 1 stop bit, LSB first, at 115200 baud or 4M baud from a 125 MHz clock. It pairs with the design's 8n1 transmitter and delivers each received byte on a valid/ready output. It detects framing errors and overruns and flags each with a one-cycle pulse.

Parameters:
SLOW_DIV, 1085, clk cycles per bit at 115200 baud (125 MHz / 115200).
FAST_DIV, 31, clk cycles per bit at 4M baud (test mode).

Ports:
clk  input  1  system clock, 125 MHz.
rst  input  1  synchronous, active-low reset. All state is cleared on a clk edge where rst==0.
rx  input  1  asynchronous serial line. Idles high.
data  output  8  received byte. Valid only while valid==1.
valid  output  1  byte available.
ready  input  1  consumer accepts. A transfer occurs on a cycle with valid && ready.
frame_error  output  1  one-cycle pulse when the stop bit is sampled low.
overflow  output  1  one-cycle pulse when a completed byte is dropped because the output is still occupied.
high_speed  input  1  selects FAST_DIV (1) or SLOW_DIV (0). Latched at start-bit detection.

Behaviour:
- rx passes through a 2-flop synchronizer. The synchronizer flops reset to 1. All decisions use the synchronized value rs.
- Reset values: valid=0, data=0, frame_error=0, overflow=0, FSM=IDLE, synchronizer=2'b11.
- Bit timer: an 11-bit down-counter. Loading N makes it expire N+1 cycles later, on the cycle it reads 0. div is the latched SLOW_DIV or FAST_DIV value.
- FSM states:
  - IDLE: when rs==0, latch div from high_speed, load (div/2)-1, go to START.
  - START: on expiry, sample rs. If rs==1, treat it as a glitch and return to IDLE with nothing reported. If rs==0, load div-1, clear the bit count, go to DATA.
  - DATA: on each expiry, shift rs into shreg[7] (right shift, so LSB-first), reload div-1, increment the bit count. After the 8th sample, go to STOP.
  - STOP: on expiry, sample rs.
    - rs==1, valid==0: data<=shreg, valid<=1, go to IDLE.
    - rs==1, valid==1 (and not accepted this cycle): drop the new byte, leave data unchanged, pulse overflow, go to IDLE.
    - rs==0: pulse frame_error, discard the byte, go to BREAK.
  - BREAK: wait for rs==1, then go to IDLE. This prevents a held-low line from retriggering start detection.
- STOP returns to IDLE at mid-stop-bit, so a start bit arriving right after the stop bit is caught.
- Output handshake:
  - valid falls on the cycle after valid && ready.
  - data is stable while valid==1.
  - Delivery and acceptance in the same cycle count as a successful delivery: valid stays 1 with the new data, and overflow does not pulse.
- Latency: the rising edge of valid comes 2 (synchronizer) + div/2 + 9*div cycles after the rx falling edge, ±1. No compensation is made for synchronizer delay.
- Changing high_speed mid-frame has no effect until the next start detection.
- Reset mid-frame: FSM goes to IDLE, valid drops, the partial byte is discarded, and no pulses are emitted.

Optional Feature:
UART_RX_MAJORITY_EN:
- Defined: every sample point (start, data, stop) uses a 2-of-3 majority of rs taken at expiry-1, expiry and expiry+1. The FSM acts on the cycle after expiry, and the timer reload is shortened by 1 to hold bit timing. Single-cycle glitches at a sample point are rejected.
- Undefined: a single sample at expiry, exactly as described in Behaviour.

Test Plan:
1. Basic receive. high_speed=1, ready=1; send 0xA5 (start, 1,0,1,0,0,1,0,1, stop), each bit 31 cycles -> valid pulses once with data=0xA5, 296–300 cycles after the falling edge; frame_error=0, overflow=0.
2. Start-bit glitch. high_speed=1; drive rx low for 10 cycles, then high for 400 cycles -> valid, frame_error and overflow stay 0; FSM is back in IDLE; a following 0x3C frame is received correctly.
3. Framing error. Send 0x81 with the stop bit low, hold rx low 200 cycles, then high; send 0x3C -> one frame_error pulse, no valid for 0x81, no further frame_error during the low hold; data=0x3C is received.
4. Overrun. ready=0; send 0x11 then 0x22 back-to-back -> valid=1, data=0x11; overflow pulses once at the mid-stop of 0x22; data stays 0x11. Raise ready -> valid falls the next cycle.
5. Slow rate, back-to-back. high_speed=0, ready=1; send 0x00 then 0xFF at 1085 cycles/bit with no idle gap -> two valids, data 0x00 then 0xFF, no errors.
6. Reset mid-frame. Assert rst=0 for 1 cycle during data bit 3 of a fast frame, then hold rx high 400 cycles -> valid=0 with no pulses; a following 0x5A is received correctly. With UART_RX_MAJORITY_EN, also send 0x00 with a 1-cycle high glitch at the data bit 0 sample point -> data=0x00 (without the macro, data=0x01).

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx -- fixed-format 8n1 UART receiver (8 data bits, no parity, 1 stop,
// LSB first). Bit period is SLOW_DIV or FAST_DIV clk cycles. high_speed
// chooses between them and is latched when a start bit is detected.
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-low reset; clears all state
//   rx           asynchronous serial input, idles high
//   data[7:0]    received byte, held stable while valid==1
//   valid        byte available
//   ready        consumer accepts; a transfer happens on valid && ready
//   frame_error  one-cycle pulse when the stop bit is sampled low
//   overflow     one-cycle pulse when a completed byte is dropped because the
//                output still holds an unaccepted byte
//   high_speed   1 = FAST_DIV, 0 = SLOW_DIV
//
// Build option:
//   UART_RX_MAJORITY_EN  when defined, every sample point takes a 2-of-3
//                        majority of rs at expiry-1/expiry/expiry+1. The FSM
//                        acts one cycle after expiry, and the reload is one
//                        cycle shorter so the bit spacing stays the same.
module uart_rx #(
   parameter int SLOW_DIV = 1085,
   parameter int FAST_DIV = 31
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   input  logic       ready,
   output logic       frame_error,
   output logic       overflow,
   input  logic       high_speed
);

   localparam logic [10:0] SLOW_W = 11'(SLOW_DIV);
   localparam logic [10:0] FAST_W = 11'(FAST_DIV);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_BREAK
   } state_t;

   state_t      state, state_nxt;
   logic        rx_meta, rs;
   logic [10:0] cnt;
   logic [10:0] div;
   logic [10:0] div_sel;
   logic [7:0]  shreg;
   logic [2:0]  bit_cnt;
   logic        timed;
   logic        act;
   logic        smp;
   logic        load_half, load_bit, clr_bits, shift_en;
   logic        deliver, ovf_nxt, fe_nxt;

   assign timed   = (state == ST_START) || (state == ST_DATA) || (state == ST_STOP);
   assign div_sel = high_speed ? FAST_W : SLOW_W;

`ifdef UART_RX_MAJORITY_EN
   // Reload shortened by one: the FSM acts one cycle after expiry.
   localparam logic [10:0] RELOAD_ADJ = 11'd2;

   logic rs_d1, rs_d2, exp_d;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   always_ff @(posedge clk) begin
      if (!rst) begin
         rs_d1 <= 1'b1;
         rs_d2 <= 1'b1;
         exp_d <= 1'b0;
      end else begin
         rs_d1 <= rs;
         rs_d2 <= rs_d1;
         // The timer holds at 0 during the act cycle; !exp_d keeps this a single pulse.
         exp_d <= timed && (cnt == 11'd0) && !exp_d;
      end
   end

   // In the act cycle: rs = expiry+1, rs_d1 = expiry, rs_d2 = expiry-1.
   assign act = exp_d;
   assign smp = maj3(rs_d2, rs_d1, rs);
`else
   localparam logic [10:0] RELOAD_ADJ = 11'd1;

   assign act = timed && (cnt == 11'd0);
   assign smp = rs;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (!rs) state_nxt = ST_START;
         ST_START: if (act) state_nxt = smp ? ST_IDLE : ST_DATA;
         ST_DATA:  if (act && (bit_cnt == 3'd7)) state_nxt = ST_STOP;
         // Leaving at mid-stop-bit lets a start bit that follows at once be caught.
         ST_STOP:  if (act) state_nxt = smp ? ST_IDLE : ST_BREAK;
         // A line held low must go high before a new start can be seen.
         ST_BREAK: if (rs) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Output / control decode
   always_comb begin
      load_half = 1'b0;
      load_bit  = 1'b0;
      clr_bits  = 1'b0;
      shift_en  = 1'b0;
      deliver   = 1'b0;
      ovf_nxt   = 1'b0;
      fe_nxt    = 1'b0;
      case (state)
         ST_IDLE:  load_half = !rs;
         ST_START: begin
            if (act && !smp) begin
               load_bit = 1'b1;
               clr_bits = 1'b1;
            end
         end
         ST_DATA: begin
            if (act) begin
               shift_en = 1'b1;
               load_bit = 1'b1;
            end
         end
         ST_STOP: begin
            if (act) begin
               if (smp) begin
                  // A byte accepted this same cycle frees the slot for the new one.
                  if (!valid || ready) deliver = 1'b1;
                  else                 ovf_nxt = 1'b1;
               end else begin
                  fe_nxt = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   // Datapath, timer and output registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         rx_meta     <= 1'b1;
         rs          <= 1'b1;
         cnt         <= 11'd0;
         div         <= 11'd0;
         shreg       <= 8'd0;
         bit_cnt     <= 3'd0;
         data        <= 8'd0;
         valid       <= 1'b0;
         frame_error <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         rx_meta <= rx;
         rs      <= rx_meta;

         // Loading N expires N+1 cycles later, on the cycle cnt reads 0.
         if (load_half) begin
            div <= div_sel;
            cnt <= (div_sel >> 1) - 11'd1;
         end else if (load_bit) begin
            cnt <= div - RELOAD_ADJ;
         end else if (cnt != 11'd0) begin
            cnt <= cnt - 11'd1;
         end

         if (clr_bits)      bit_cnt <= 3'd0;
         else if (shift_en) bit_cnt <= bit_cnt + 3'd1;

         // Right shift: the first (LSB) bit ends up in shreg[0].
         if (shift_en) shreg <= {smp, shreg[7:1]};

         if (deliver) begin
            data  <= shreg;
            valid <= 1'b1;
         end else if (valid && ready) begin
            valid <= 1'b0;
         end

         frame_error <= fe_nxt;
         overflow    <= ovf_nxt;
      end
   end

endmodule
